// File: rtl/sap1_controller_sequencer.sv
// -----------------------------------------------------------------------------
// sap1_controller_sequencer
//
// Control unit for the SAP-1 datapath. A six-state one-hot ring counter
// (T1..T6) sequences every instruction. A combinational decoder turns the
// current T-state and the opcode nibble into the 12-bit control word and the
// halt flag.
//
// Ports:
//   CLK     in   1   system clock, all state changes on the rising edge
//   CLR     in   1   asynchronous active-high reset, returns the ring to T1
//   OPCODE  in   4   upper nibble of the instruction register, valid from T4
//   T       out  6   one-hot ring state, T[0]=T1 .. T[5]=T6 (FSM debug view)
//   CON     out  12  control word, [11:0] = Cp Ep LM_bar CE_bar LI_bar EI_bar
//                    LA_bar EA Su EU LB_bar LO_bar
//   HLT     out  1   halt flag, high from the HLT decode in T4 until CLR
//
// CON and HLT have no registered stage: they follow T, OPCODE and the halted
// bit within the same cycle.
// -----------------------------------------------------------------------------
module sap1_controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [3:0]  OPCODE,
    output logic [5:0]  T,
    output logic [11:0] CON,
    output logic        HLT
);

    // One-hot encoding is the state encoding itself, so T is just the state
    // register and can never hold anything other than one of these values.
    typedef enum logic [5:0] {
        ST_T1 = 6'b000001,
        ST_T2 = 6'b000010,
        ST_T3 = 6'b000100,
        ST_T4 = 6'b001000,
        ST_T5 = 6'b010000,
        ST_T6 = 6'b100000
    } ring_t;

    // Control words. Idle has every active-high signal at 0 and every _bar
    // signal at 1; the others differ from idle only in the signals named.
    localparam logic [11:0] CON_IDLE     = 12'h3E3;
    localparam logic [11:0] CON_FETCH_T1 = 12'h5E3; // Ep, LM_bar
    localparam logic [11:0] CON_FETCH_T2 = 12'hBE3; // Cp
    localparam logic [11:0] CON_FETCH_T3 = 12'h263; // CE_bar, LI_bar
    localparam logic [11:0] CON_ADDR_T4  = 12'h1A3; // EI_bar, LM_bar
    localparam logic [11:0] CON_LDA_T5   = 12'h2C3; // CE_bar, LA_bar
    localparam logic [11:0] CON_ARITH_T5 = 12'h2E1; // CE_bar, LB_bar
    localparam logic [11:0] CON_ADD_T6   = 12'h3C7; // EU, LA_bar
    localparam logic [11:0] CON_SUB_T6   = 12'h3CF; // Su, EU, LA_bar
    localparam logic [11:0] CON_OUT_T4   = 12'h3F2; // EA, LO_bar

    ring_t state_q;
    ring_t state_d;
    logic  halted_q;
    logic  halted_d;
    logic  halt_decode;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q  <= ST_T1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        halted_d    = halted_q;
        CON         = CON_IDLE;
        halt_decode = 1'b0;

        // Once halted the ring is frozen at T4 and the word stays idle.
        if (!halted_q) begin
            case (state_q)
                ST_T1: begin
                    CON     = CON_FETCH_T1;
                    state_d = ST_T2;
                end
                ST_T2: begin
                    CON     = CON_FETCH_T2;
                    state_d = ST_T3;
                end
                ST_T3: begin
                    CON     = CON_FETCH_T3;
                    state_d = ST_T4;
                end
                ST_T4: begin
                    state_d = ST_T5;
                    if (OPCODE == OP_LDA || OPCODE == OP_ADD || OPCODE == OP_SUB) begin
                        CON = CON_ADDR_T4;
                    end else if (OPCODE == OP_OUT) begin
                        CON = CON_OUT_T4;
                    end else if (OPCODE == OP_HLT) begin
                        // Hold T4 on the coming edge and latch the halt.
                        halt_decode = 1'b1;
                        halted_d    = 1'b1;
                        state_d     = ST_T4;
                    end
                end
                ST_T5: begin
                    state_d = ST_T6;
                    if (OPCODE == OP_LDA) begin
                        CON = CON_LDA_T5;
                    end else if (OPCODE == OP_ADD || OPCODE == OP_SUB) begin
                        CON = CON_ARITH_T5;
                    end
                end
                ST_T6: begin
                    state_d = ST_T1;
                    if (OPCODE == OP_ADD) begin
                        CON = CON_ADD_T6;
                    end else if (OPCODE == OP_SUB) begin
                        CON = CON_SUB_T6;
                    end
                end
                default: begin
                    state_d = ST_T1;
                end
            endcase
        end
    end

    assign T   = state_q;
    assign HLT = halted_q | halt_decode;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sap1_controller_sequencer
//
// Directed and random stimulus for the SAP-1 controller-sequencer. Every
// expected {T, HLT, CON} triple is pushed to exp_q when the step is driven and
// popped when the DUT outputs are sampled.
// -----------------------------------------------------------------------------
module tb_sap1_controller_sequencer;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [3:0]  OPCODE;
    logic [5:0]  T;
    logic [11:0] CON;
    logic        HLT;

    logic [18:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    // bench-side model state for the random phase
    int   m_ti;
    logic m_halted;

    sap1_controller_sequencer dut (
        .CLK    (CLK),
        .CLR    (CLR),
        .OPCODE (OPCODE),
        .T      (T),
        .CON    (CON),
        .HLT    (HLT)
    );

    // clock / reset block
    always #5 CLK = ~CLK;

    // reference control word table for (T index, opcode), HLT excluded
    function automatic logic [11:0] model_con(input int ti, input logic [3:0] op);
        logic [11:0] w;
        w = 12'h3E3;
        case (ti)
            0: w = 12'h5E3;
            1: w = 12'hBE3;
            2: w = 12'h263;
            3: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) w = 12'h1A3;
                else if (op == 4'hE) w = 12'h3F2;
            end
            4: begin
                if (op == 4'h0) w = 12'h2C3;
                else if (op == 4'h1 || op == 4'h2) w = 12'h2E1;
            end
            5: begin
                if (op == 4'h1) w = 12'h3C7;
                else if (op == 4'h2) w = 12'h3CF;
            end
            default: w = 12'h3E3;
        endcase
        return w;
    endfunction

    task automatic push_exp(input logic [5:0] t, input logic h, input logic [11:0] con);
        exp_q.push_back({t, h, con});
    endtask

    task automatic check(input string tag);
        logic [18:0] e;
        logic [18:0] o;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: no expected entry queued, observed T=%b HLT=%b CON=%h", tag, T, HLT, CON);
            return;
        end
        e = exp_q.pop_front();
        o = {T, HLT, CON};
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed T=%b HLT=%b CON=%h expected T=%b HLT=%b CON=%h",
                   tag, o[18:13], o[12], o[11:0], e[18:13], e[12], e[11:0]);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // driver: apply opcode, check the current T-state outputs, then clock
    task automatic step(input string tag, input logic [3:0] op,
                        input logic [5:0] t, input logic h, input logic [11:0] con);
        OPCODE = op;
        #1;
        push_exp(t, h, con);
        check(tag);
        tick();
    endtask

    task automatic run_pass(input string tag, input logic [3:0] op,
                            input logic [11:0] w0, input logic [11:0] w1, input logic [11:0] w2,
                            input logic [11:0] w3, input logic [11:0] w4, input logic [11:0] w5);
        logic [11:0] w[6];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4; w[5] = w5;
        for (int i = 0; i < 6; i++) begin
            step($sformatf("%s_t%0d", tag, i + 1), op, 6'(1 << i), 1'b0, w[i]);
        end
    endtask

    initial begin
        logic [3:0] rop;
        logic [11:0] mcon;
        logic mh;

        CLR    = 1'b1;
        OPCODE = 4'h0;
        #2;
        push_exp(6'b000001, 1'b0, 12'h5E3);
        check("reset");
        CLR = 1'b0;
        #1;

        // LDA, then ADD with wrap back to T1
        run_pass("lda", 4'h0, 12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2C3, 12'h3E3);
        run_pass("add", 4'h1, 12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3C7);
        run_pass("sub", 4'h2, 12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3CF);
        run_pass("out", 4'hE, 12'h5E3, 12'hBE3, 12'h263, 12'h3F2, 12'h3E3, 12'h3E3);
        run_pass("nop5", 4'h5, 12'h5E3, 12'hBE3, 12'h263, 12'h3E3, 12'h3E3, 12'h3E3);

        // opcode churn during fetch is ignored; execute follows the live opcode
        step("fetch_op_f", 4'hF, 6'b000001, 1'b0, 12'h5E3);
        step("fetch_op_1", 4'h1, 6'b000010, 1'b0, 12'hBE3);
        step("fetch_op_e", 4'hE, 6'b000100, 1'b0, 12'h263);
        step("exec_lda_t4", 4'h0, 6'b001000, 1'b0, 12'h1A3);
        step("exec_lda_t5", 4'h0, 6'b010000, 1'b0, 12'h2C3);
        step("exec_sub_t6", 4'h2, 6'b100000, 1'b0, 12'h3CF);

        // asynchronous reset in the middle of T5
        step("pre_rst_t1", 4'h0, 6'b000001, 1'b0, 12'h5E3);
        step("pre_rst_t2", 4'h0, 6'b000010, 1'b0, 12'hBE3);
        step("pre_rst_t3", 4'h0, 6'b000100, 1'b0, 12'h263);
        step("pre_rst_t4", 4'h0, 6'b001000, 1'b0, 12'h1A3);
        #1;
        push_exp(6'b010000, 1'b0, 12'h2C3);
        check("pre_rst_t5");
        CLR = 1'b1;
        #1;
        push_exp(6'b000001, 1'b0, 12'h5E3);
        check("rst_mid_t5");
        CLR = 1'b0;
        #1;
        step("post_rst_t1", 4'h0, 6'b000001, 1'b0, 12'h5E3);
        step("post_rst_t2", 4'h0, 6'b000010, 1'b0, 12'hBE3);
        step("post_rst_t3", 4'h0, 6'b000100, 1'b0, 12'h263);
        step("post_rst_t4", 4'h0, 6'b001000, 1'b0, 12'h1A3);
        step("post_rst_t5", 4'h0, 6'b010000, 1'b0, 12'h2C3);
        step("post_rst_t6", 4'h0, 6'b100000, 1'b0, 12'h3E3);

        // halt: decoded in T4, then frozen until CLR
        step("hlt_t1", 4'hF, 6'b000001, 1'b0, 12'h5E3);
        step("hlt_t2", 4'hF, 6'b000010, 1'b0, 12'hBE3);
        step("hlt_t3", 4'hF, 6'b000100, 1'b0, 12'h263);
        step("hlt_decode", 4'hF, 6'b001000, 1'b1, 12'h3E3);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("hlt_hold%0d", i), 4'hF, 6'b001000, 1'b1, 12'h3E3);
        end
        step("hlt_op0", 4'h0, 6'b001000, 1'b1, 12'h3E3);
        step("hlt_op1", 4'h1, 6'b001000, 1'b1, 12'h3E3);
        step("hlt_ope", 4'hE, 6'b001000, 1'b1, 12'h3E3);
        CLR = 1'b1;
        #1;
        push_exp(6'b000001, 1'b0, 12'h5E3);
        check("hlt_clr");
        CLR = 1'b0;
        #1;
        step("after_hlt_t1", 4'h0, 6'b000001, 1'b0, 12'h5E3);
        step("after_hlt_t2", 4'h0, 6'b000010, 1'b0, 12'hBE3);

        // random opcodes (HLT excluded) against the table model
        m_ti     = 2;
        m_halted = 1'b0;
        for (int i = 0; i < 100; i++) begin
            rop = 4'($urandom_range(0, 14));
            mcon = model_con(m_ti, rop);
            mh   = 1'b0;
            OPCODE = rop;
            #1;
            checks++;
            assert ($onehot(T)) else begin
                errors++;
                $error("FAIL onehot%0d: observed T=%b expected exactly one bit set", i, T);
            end
            push_exp(6'(1 << m_ti), mh, mcon);
            check($sformatf("rand%0d_op%h", i, rop));
            tick();
            m_ti = (m_ti + 1) % 6;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
